flash_mem_responder: RTL

- Avalon-MM read responder that emulates the flash_mem slave interface of the flash IP, serving word reads and bursts from a synchronous on-chip ROM.
- Lets read_flash and address_fsm run against a known sample image in simulation and on-board bring-up, with no dependency on real flash timing.
- Wait states are programmable; bursts are supported.
- Sits in place of the flash instance: the master-side flash_mem_* signals connect here, and the ROM port connects to an altsyncram-style ROM.

---
 rtl/flash_resp_pkg.sv | 30 +++
 rtl/flash_beat_pipe.sv | 44 ++++
 rtl/flash_mem_responder.sv | 134 +++++++++++++
 3 files changed

// File: rtl/flash_resp_pkg.sv
// Shared types, constants and the byte-lane masking helper for the flash_mem read responder.
package flash_resp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    STALL,
    ACCEPT,
    BURST,
    DRAIN
  } state_t;

  localparam int WAIT_CNT_WIDTH = 4;

  // Widest readdata the helper supports; narrower buses are zero-extended into it.
  localparam int MAX_DATA_WIDTH = 256;
  localparam int MAX_BE_WIDTH   = MAX_DATA_WIDTH / 8;

  function automatic logic [MAX_DATA_WIDTH-1:0] apply_byteenable(
    input logic [MAX_DATA_WIDTH-1:0] data,
    input logic [MAX_BE_WIDTH-1:0]   be
  );
    logic [MAX_DATA_WIDTH-1:0] res;
    res = data;
    for (int i = 0; i < MAX_BE_WIDTH; i++) begin
      if (!be[i]) res[i*8 +: 8] = 8'h00;
    end
    return res;
  endfunction

endpackage

// File: rtl/flash_beat_pipe.sv
// Aligns readdatavalid with the one-cycle ROM latency and masks disabled byte lanes.
module flash_beat_pipe
  import flash_resp_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    issue,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [DATA_WIDTH-1:0]   rom_q,
  output logic [DATA_WIDTH-1:0]   readdata,
  output logic                    readdatavalid
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;

  logic                      vld_p1;
  logic [BE_WIDTH-1:0]       be_p1;
  logic [DATA_WIDTH-1:0]     hold_p1;
  logic [MAX_DATA_WIDTH-1:0] masked_wide;
  logic [DATA_WIDTH-1:0]     masked_p1;
  logic                      unused_hi;

  // Stage p1: ROM word for the address issued last cycle is on rom_q now
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1  <= 1'b0;
      be_p1   <= '0;
      hold_p1 <= '0;
    end else begin
      vld_p1 <= issue;
      be_p1  <= be;
      if (vld_p1) hold_p1 <= masked_p1;
    end
  end

  assign masked_wide   = apply_byteenable(MAX_DATA_WIDTH'(rom_q), MAX_BE_WIDTH'(be_p1));
  assign masked_p1     = masked_wide[DATA_WIDTH-1:0];
  assign unused_hi     = ^masked_wide;
  assign readdatavalid = vld_p1;
  assign readdata      = vld_p1 ? masked_p1 : hold_p1;

endmodule

// File: rtl/flash_mem_responder.sv
// Avalon-MM read responder standing in for the flash_mem slave, serving reads and bursts from a sync ROM.
module flash_mem_responder
  import flash_resp_pkg::*;
#(
  parameter int ADDR_WIDTH  = 23,
  parameter int DATA_WIDTH  = 32,
  parameter int BURST_WIDTH = 7,
  parameter int WAIT_STATES = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    flash_mem_read,
  input  logic                    flash_mem_write,
  input  logic [ADDR_WIDTH-1:0]   flash_mem_address,
  input  logic [BURST_WIDTH-1:0]  flash_mem_burstcount,
  input  logic [DATA_WIDTH/8-1:0] flash_mem_byteenable,
  input  logic [DATA_WIDTH-1:0]   flash_mem_writedata,
  output logic                    flash_mem_waitrequest,
  output logic [DATA_WIDTH-1:0]   flash_mem_readdata,
  output logic                    flash_mem_readdatavalid,
  output logic [ADDR_WIDTH-1:0]   rom_address,
  input  logic [DATA_WIDTH-1:0]   rom_q,
  output logic                    protocol_err
);

  localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_LOAD = WAIT_CNT_WIDTH'(WAIT_STATES);

  state_t                    state_q, state_d;
  logic [WAIT_CNT_WIDTH-1:0] wait_cnt_q, wait_cnt_d;
  logic [ADDR_WIDTH-1:0]     rom_addr_q, rom_addr_d;
  logic [DATA_WIDTH/8-1:0]   be_q, be_d;
  logic [BURST_WIDTH-1:0]    beats_q, beats_d;
  logic [BURST_WIDTH-1:0]    beat_idx_q, beat_idx_d;
  logic                      err_q, err_d;
  logic                      issue;
  logic                      cmd;
  logic                      unused_wdata;

  assign cmd          = flash_mem_read | flash_mem_write;
  assign unused_wdata = ^flash_mem_writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      rom_addr_q <= '0;
      be_q       <= '0;
      beats_q    <= '0;
      beat_idx_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      rom_addr_q <= rom_addr_d;
      be_q       <= be_d;
      beats_q    <= beats_d;
      beat_idx_q <= beat_idx_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    rom_addr_d = rom_addr_q;
    be_d       = be_q;
    beats_d    = beats_q;
    beat_idx_d = beat_idx_q;
    err_d      = err_q;
    issue      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd) begin
          if (WAIT_STATES == 0) begin
            state_d = ACCEPT;
          end else begin
            wait_cnt_d = WAIT_LOAD;
            state_d    = STALL;
          end
        end
      end
      STALL: begin
        if (!cmd) begin
          state_d = IDLE;
        end else if (wait_cnt_q == WAIT_CNT_WIDTH'(1)) begin
          state_d = ACCEPT;
        end else begin
          wait_cnt_d = wait_cnt_q - WAIT_CNT_WIDTH'(1);
        end
      end
      ACCEPT: begin
        // A simultaneous write is folded into the read; only reads produce beats
        if (flash_mem_read) begin
          rom_addr_d = flash_mem_address;
          be_d       = flash_mem_byteenable;
          beat_idx_d = '0;
          beats_d    = (flash_mem_burstcount == '0) ? BURST_WIDTH'(1) : flash_mem_burstcount;
          if (flash_mem_burstcount == '0 || flash_mem_write) err_d = 1'b1;
          state_d    = BURST;
        end else begin
          state_d = IDLE;
        end
      end
      BURST: begin
        issue = 1'b1;
        if (beat_idx_q == beats_q - BURST_WIDTH'(1)) begin
          state_d = DRAIN;
        end else begin
          beat_idx_d = beat_idx_q + BURST_WIDTH'(1);
          rom_addr_d = rom_addr_q + ADDR_WIDTH'(1);
        end
      end
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign flash_mem_waitrequest = (state_q != ACCEPT);
  assign rom_address           = rom_addr_q;
  assign protocol_err          = err_q;

  flash_beat_pipe #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_beat_pipe (
    .clk          (clk),
    .reset_n      (reset_n),
    .issue        (issue),
    .be           (be_q),
    .rom_q        (rom_q),
    .readdata     (flash_mem_readdata),
    .readdatavalid(flash_mem_readdatavalid)
  );

endmodule
